// File: rtl/inter_residual.sv
// inter_residual: motion-compensated residual rows with a 2-entry output FIFO; INTER_RES_SAD_EN adds a SAD cross-check
module inter_residual #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mv_valid,
    output logic        mv_ready,
    input  logic [5:0]  mv_x,
    input  logic [5:0]  mv_y,
    input  logic [15:0] min_sad,
    output logic        rd_en,
    output logic [5:0]  sw_row,
    output logic [5:0]  sw_col,
    output logic [5:0]  cur_row,
    input  logic [7:0]  sw_rd_data  [0:MACRO_DIM-1],
    input  logic [7:0]  cur_rd_data [0:MACRO_DIM-1],
    output logic        res_valid,
    input  logic        res_ready,
    output logic [8:0]  res_data    [0:MACRO_DIM-1],
    output logic [7:0]  pred_data   [0:MACRO_DIM-1],
    output logic [5:0]  res_row,
    output logic        res_last,
    output logic        done,
    output logic        sad_mismatch
);
    localparam logic [5:0] LAST = 6'(MACRO_DIM - 1);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state;
    logic [5:0] mvx_q, mvy_q, row, ret_row;
    logic inflight, accept, pop, push, issue, fin, wr;
    logic [1:0] fcnt, nxt_cnt;
    logic [MACRO_DIM*9-1:0] f_res [0:1];
    logic [MACRO_DIM*8-1:0] f_pred [0:1];
    logic [5:0] f_row [0:1];
    logic [MACRO_DIM*9-1:0] new_res;
    logic [MACRO_DIM*8-1:0] new_pred;
    logic [8:0] diff [0:MACRO_DIM-1];

    if (SEARCH_DIM - MACRO_DIM > 63) begin : g_range_chk
        $error("search window offset does not fit the 6-bit motion vector");
    end

    assign accept = state == IDLE && mv_valid;
    assign mv_ready = state == IDLE;
    assign res_valid = fcnt != 2'd0;
    assign pop = res_valid && res_ready;
    assign push = inflight;
    // fcnt + inflight never exceeds 2, so a pop always frees room for one more read
    assign issue = state == FETCH && ((fcnt + 2'(inflight)) < 2'd2 || pop);
    assign rd_en = issue;
    assign nxt_cnt = fcnt + 2'(push) - 2'(pop);
    assign wr = 1'(fcnt - 2'(pop));
    assign fin = state == DRAIN && !done && nxt_cnt == 2'd0;
    assign sw_row = mvy_q + row;
    assign sw_col = mvx_q;
    assign cur_row = row;
    assign res_row = f_row[0];
    assign res_last = res_valid && f_row[0] == LAST;

    for (genvar i = 0; i < MACRO_DIM; i++) begin : g_px
        assign diff[i] = {1'b0, cur_rd_data[i]} - {1'b0, sw_rd_data[i]};
        assign new_res[i*9 +: 9] = diff[i];
        assign new_pred[i*8 +: 8] = sw_rd_data[i];
        assign res_data[i] = f_res[0][i*9 +: 9];
        assign pred_data[i] = f_pred[0][i*8 +: 8];
    end

    // Control FSM: accept a vector, issue one row read per permitted cycle, then wait for the FIFO to drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            row <= '0;
            mvx_q <= '0;
            mvy_q <= '0;
            done <= 1'b0;
        end else begin
            done <= fin;
            case (state)
                IDLE: if (accept) begin
                    mvx_q <= mv_x;
                    mvy_q <= mv_y;
                    row <= '0;
                    state <= FETCH;
                end
                FETCH: if (issue) begin
                    state <= row == LAST ? DRAIN : FETCH;
                    row <= row == LAST ? row : row + 6'd1;
                end
                DRAIN: state <= done ? IDLE : DRAIN;
                default: state <= IDLE;
            endcase
        end
    end

    // Read-return tracking and the two-entry output FIFO; push lands behind a same-cycle pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            ret_row <= '0;
            fcnt <= '0;
            f_res[0] <= '0;
            f_res[1] <= '0;
            f_pred[0] <= '0;
            f_pred[1] <= '0;
            f_row[0] <= '0;
            f_row[1] <= '0;
        end else begin
            inflight <= issue;
            ret_row <= issue ? row : ret_row;
            fcnt <= nxt_cnt;
            if (pop) begin
                f_res[0] <= f_res[1];
                f_pred[0] <= f_pred[1];
                f_row[0] <= f_row[1];
            end
            if (push) begin
                f_res[wr] <= new_res;
                f_pred[wr] <= new_pred;
                f_row[wr] <= ret_row;
            end
        end
    end

`ifdef INTER_RES_SAD_EN
    logic [15:0] sad_acc, min_sad_q, row_sad;

    // Sum of absolute residuals of the row returning this cycle
    always_comb begin
        row_sad = '0;
        for (int k = 0; k < MACRO_DIM; k++)
            row_sad = row_sad + 16'(diff[k][8] ? 9'(-diff[k]) : diff[k]);
    end

    // Accumulate SAD over the block and compare it with the reported value as the block completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sad_acc <= '0;
            min_sad_q <= '0;
            sad_mismatch <= 1'b0;
        end else if (accept) begin
            sad_acc <= '0;
            min_sad_q <= min_sad;
            sad_mismatch <= 1'b0;
        end else begin
            sad_acc <= push ? sad_acc + row_sad : sad_acc;
            sad_mismatch <= fin ? sad_acc != min_sad_q : sad_mismatch;
        end
    end
`else
    logic unused_min_sad;
    assign unused_min_sad = ^min_sad;
    assign sad_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_inter_residual.sv
// tb_inter_residual: directed vector table plus hand sequences for stall, back-to-back vectors and mid-block reset
module tb_inter_residual;
    localparam int MD = 16;

    typedef struct {
        int mvx;
        int mvy;
        int cv;
        int rv;
        int msad;
        int stall;
        int exp_done;
        int exp_mm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mv_valid = 1'b0;
    logic res_ready = 1'b0;
    logic [5:0] mv_x = '0;
    logic [5:0] mv_y = '0;
    logic [15:0] min_sad = '0;
    logic mv_ready, rd_en, res_valid, res_last, done, sad_mismatch;
    logic [5:0] sw_row, sw_col, cur_row, res_row;
    logic [7:0] sw_rd_data [0:MD-1];
    logic [7:0] cur_rd_data [0:MD-1];
    logic [8:0] res_data [0:MD-1];
    logic [7:0] pred_data [0:MD-1];
    logic [7:0] sw_mem [0:47][0:47];
    logic [7:0] cur_mem [0:MD-1][0:MD-1];
    int checks = 0;
    int passed = 0;
    int ovf = 0;

    inter_residual #(.MACRO_DIM(MD), .SEARCH_DIM(48)) dut (
        .clk(clk), .rst_n(rst_n), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad), .rd_en(rd_en),
        .sw_row(sw_row), .sw_col(sw_col), .cur_row(cur_row),
        .sw_rd_data(sw_rd_data), .cur_rd_data(cur_rd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .pred_data(pred_data), .res_row(res_row), .res_last(res_last),
        .done(done), .sad_mismatch(sad_mismatch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            for (int i = 0; i < MD; i++) begin
                sw_rd_data[i] <= sw_mem[int'(sw_row)][int'(sw_col) + i];
                cur_rd_data[i] <= cur_mem[int'(cur_row)][i];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && int'(dut.fcnt) + int'(dut.inflight) > 2) ovf++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fill(input int cv, input int rv);
        for (int y = 0; y < 48; y++)
            for (int x = 0; x < 48; x++)
                sw_mem[y][x] = rv < 0 ? 8'((y * 7 + x * 3) & 255) : 8'(rv);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                cur_mem[r][c] = cv < 0 ? 8'(r * 8 + c + 50) : 8'(cv);
    endtask

    function automatic int row_bad(input vec_t v, input int r);
        int bad = 0;
        if (r >= MD) return 1;
        for (int c = 0; c < MD; c++) begin
            int e;
            e = int'(cur_mem[r][c]) - int'(sw_mem[v.mvy + r][v.mvx + c]);
            if (int'($signed(res_data[c])) != e) bad++;
            if (pred_data[c] != sw_mem[v.mvy + r][v.mvx + c]) bad++;
        end
        return bad;
    endfunction

    task automatic chk_reset(input string tag);
        int bad = 0;
        for (int i = 0; i < MD; i++) if (res_data[i] != 9'd0 || pred_data[i] != 8'd0) bad++;
        chk({tag, "_mv_ready"}, int'(mv_ready), 1);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_last"}, int'(res_last), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_sad_mismatch"}, int'(sad_mismatch), 0);
        chk({tag, "_addr"}, int'(sw_row) + int'(sw_col) + int'(cur_row) + int'(res_row), 0);
        chk({tag, "_data"}, bad, 0);
    endtask

    task automatic run_block(input vec_t v);
        int issued = 0;
        int nrow = 0;
        int first_rd = -1;
        int first_val = -1;
        int done_t = -1;
        int em = 0;
`ifdef INTER_RES_SAD_EN
        em = v.exp_mm;
`endif
        fill(v.cv, v.rv);
        @(posedge clk); #1;
        mv_valid = 1'b1;
        mv_x = 6'(v.mvx);
        mv_y = 6'(v.mvy);
        min_sad = 16'(v.msad);
        res_ready = 1'b1;
        @(negedge clk);
        chk("accept_ready", int'(mv_ready), 1);
        for (int t = 1; t <= 80; t++) begin
            @(posedge clk); #1;
            mv_valid = 1'b0;
            res_ready = !(t >= 3 && t < 3 + v.stall);
            @(negedge clk);
            if (t == 1) begin
                chk("busy_ready", int'(mv_ready), 0);
                chk("mm_clear_on_accept", int'(sad_mismatch), 0);
            end
            if (rd_en) begin
                chk("sw_row", int'(sw_row), v.mvy + issued);
                chk("sw_col", int'(sw_col), v.mvx);
                chk("cur_row", int'(cur_row), issued);
                if (first_rd < 0) first_rd = t;
                issued++;
            end
            if (res_valid && first_val < 0) first_val = t;
            if (v.stall > 0 && t == 2 + v.stall) begin
                chk("stall_valid", int'(res_valid), 1);
                chk("stall_head_row", int'(res_row), 0);
                chk("stall_head_data", row_bad(v, 0), 0);
                chk("stall_reads", issued, 2);
            end
            if (res_valid && res_ready) begin
                chk("res_row", int'(res_row), nrow);
                chk("res_last", int'(res_last), int'(nrow == MD - 1));
                chk("row_data", row_bad(v, nrow), 0);
                nrow++;
            end
            if (done && done_t < 0) begin
                done_t = t;
                chk("mm_at_done", int'(sad_mismatch), em);
                chk("ready_in_done", int'(mv_ready), 0);
            end
            if (done_t > 0 && t == done_t + 1) begin
                chk("ready_after_done", int'(mv_ready), 1);
                chk("mm_held", int'(sad_mismatch), em);
                chk("done_pulse", int'(done), 0);
                break;
            end
        end
        chk("first_rd_cycle", first_rd, 1);
        chk("first_valid_cycle", first_val, 3);
        chk("done_cycle", done_t, v.exp_done);
        chk("rows_out", nrow, MD);
        chk("rows_read", issued, MD);
    endtask

    initial begin
        vec_t vecs [4];
        int acc_t [2];
        int nacc = 0;
        int ndone = 0;
        int seq = 0;
        int hbad = 0;
        vecs[0] = '{0, 0, 100, 90, 2560, 0, 19, 0};
        vecs[1] = '{32, 32, 0, 255, 65280, 0, 19, 0};
        vecs[2] = '{5, 17, -1, -1, 0, 8, 27, 1};
        vecs[3] = '{0, 0, 100, 90, 2559, 0, 19, 1};
        acc_t[0] = 0;
        acc_t[1] = 0;
        fill(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) run_block(vecs[k]);

        fill(100, 90);
        @(posedge clk); #1;
        mv_valid = 1'b1;
        mv_x = '0;
        mv_y = '0;
        min_sad = 16'd2560;
        res_ready = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (t == 1) chk("mm_clear_on_accept2", int'(sad_mismatch), 0);
            if (mv_valid && mv_ready) begin
                if (nacc < 2) acc_t[nacc] = t;
                nacc++;
            end
            if (res_valid && res_ready) begin
                if (int'(res_row) != seq % MD) hbad++;
                seq++;
            end
            if (done) ndone++;
            if (ndone == 2) break;
        end
        mv_valid = 1'b0;
        chk("held_accepts", nacc, 2);
        chk("held_gap", acc_t[1] - acc_t[0], 20);
        chk("held_rows", seq, 2 * MD);
        chk("held_order", hbad, 0);
        chk("held_dones", ndone, 2);

        fill(100, 90);
        @(posedge clk); #1;
        mv_valid = 1'b1;
        min_sad = 16'd2560;
        @(posedge clk); #1;
        mv_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", int'(res_valid), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("abort");
        @(negedge clk);
        chk("no_stale_push", int'(res_valid), 0);
        run_block(vecs[1]);

        chk("fifo_overflow", ovf, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
